// File: rtl/pipe_pkg.sv
// Shared types and constants for the handshaked pipeline-stage registers.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } stage_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  // F/D payload packing: {instr, pc, pcplus4}
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pcplus4;
  } fd_payload_t;

  localparam int unsigned FD_W = $bits(fd_payload_t);

  // addi x0,x0,0 bubble with zeroed pc fields
  localparam logic [FD_W-1:0] FLUSH_VAL_DEF = {NOP_INSTR, 32'h0, 32'h0};

  // Build an F/D payload from an instruction word and its pc
  function automatic fd_payload_t make_fd(input logic [31:0] instr, input logic [31:0] pc);
    fd_payload_t p;
    p.instr   = instr;
    p.pc      = pc;
    p.pcplus4 = pc + 32'd4;
    return p;
  endfunction

endpackage

// File: rtl/pipe_stage_skid_if.sv
// Handshake bundle for pipe_stage_skid; optional counters exist with PIPE_STAGE_PERF_EN.
interface pipe_stage_skid_if #(
  parameter int unsigned DATA_W = 96
`ifdef PIPE_STAGE_PERF_EN
  , parameter int unsigned CNT_W = 32
`endif
);

  logic              in_valid_i;
  logic              in_ready_o;
  logic [DATA_W-1:0] in_data_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [DATA_W-1:0] out_data_o;
  logic              stall_i;
  logic              flush_i;
`ifdef PIPE_STAGE_PERF_EN
  logic [CNT_W-1:0]  stall_cnt_o;
  logic [CNT_W-1:0]  flush_cnt_o;
`endif

  // Stage-side view
  modport slave (
    input  in_valid_i, in_data_i, out_ready_i, stall_i, flush_i,
    output in_ready_o, out_valid_o, out_data_o
`ifdef PIPE_STAGE_PERF_EN
    , output stall_cnt_o, flush_cnt_o
`endif
  );

  // Environment-side view (upstream, downstream and hazard unit)
  modport master (
    output in_valid_i, in_data_i, out_ready_i, stall_i, flush_i,
    input  in_ready_o, out_valid_o, out_data_o
`ifdef PIPE_STAGE_PERF_EN
    , input stall_cnt_o, flush_cnt_o
`endif
  );

endinterface

// File: rtl/pipe_perf_cnt.sv
// Wrapping event counter with synchronous clear.
module pipe_perf_cnt #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  // Count events, wrapping modulo 2^CNT_W
  always_ff @(posedge clk) begin
    if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline-stage register with 2-entry skid buffer, stall and bubble-injecting flush.
// Optional feature macro: PIPE_STAGE_PERF_EN adds stall/flush cycle counters.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int unsigned       DATA_W    = FD_W,
  parameter logic [DATA_W-1:0] FLUSH_VAL = DATA_W'(FLUSH_VAL_DEF)
`ifdef PIPE_STAGE_PERF_EN
  , parameter int unsigned     CNT_W     = 32
`endif
) (
  input logic              clk,
  input logic              rst,
  pipe_stage_skid_if.slave bus
);

  stage_state_t      state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              out_valid_q, out_valid_d;
  logic              in_ready_q, in_ready_d;
  logic              accept_c;
  logic              fire_c;

  assign accept_c = bus.in_valid_i & in_ready_q;
  assign fire_c   = out_valid_q & bus.out_ready_i & ~bus.stall_i;

  // State, storage and registered handshake outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= EMPTY;
      main_q      <= FLUSH_VAL;
      skid_q      <= FLUSH_VAL;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  // Next state and storage; flush overrides stall, accept and fire
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (bus.flush_i) begin
      state_d = EMPTY;
      main_d  = FLUSH_VAL;
      skid_d  = FLUSH_VAL;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept_c) begin
            main_d  = bus.in_data_i;
            state_d = ONE;
          end
        end
        ONE: begin
          if (accept_c && fire_c) begin
            main_d = bus.in_data_i;
          end else if (accept_c) begin
            skid_d  = bus.in_data_i;
            state_d = FULL;
          end else if (fire_c) begin
            main_d  = FLUSH_VAL;
            state_d = EMPTY;
          end
        end
        FULL: begin
          // in_ready is low here, so only draining the skid entry matters
          if (fire_c) begin
            main_d  = skid_q;
            skid_d  = FLUSH_VAL;
            state_d = ONE;
          end
        end
        default: begin
          state_d = EMPTY;
          main_d  = FLUSH_VAL;
          skid_d  = FLUSH_VAL;
        end
      endcase
    end
    out_valid_d = (state_d != EMPTY);
    in_ready_d  = (state_d != FULL);
  end

  assign bus.out_valid_o = out_valid_q;
  assign bus.in_ready_o  = in_ready_q;
  assign bus.out_data_o  = main_q;

`ifdef PIPE_STAGE_PERF_EN
  logic stall_evt_c;

  // A valid payload is held back this cycle by stall or backpressure
  assign stall_evt_c = out_valid_q & ~(bus.out_ready_i & ~bus.stall_i);

  pipe_perf_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .clr (rst),
    .inc (stall_evt_c),
    .cnt (bus.stall_cnt_o)
  );

  pipe_perf_cnt #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .clr (rst),
    .inc (bus.flush_i),
    .cnt (bus.flush_cnt_o)
  );
`endif

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised, handshaked successor to the fixed-width stall/flush pipeline registers between stages (F/D, D/E, ...).
- Carries a DATA_W payload with valid/ready on both sides, plus stall and flush inputs driven by the hazard unit.
- A 2-entry skid buffer lets in_ready_o come straight from a flop, so backpressure does not create a long combinational path.
- Flush injects a configurable bubble value, so legacy consumers that ignore valid still see a NOP.

Parameters:
- DATA_W, 96, payload width; F/D packing is {instr, pc, pcplus4}.
- FLUSH_VAL, 96'h00000013_00000000_00000000, value loaded into the output register on reset, flush or drain (addi x0,x0,0 bubble).
- CNT_W, 32, width of the performance counters (used only with the optional feature).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid_i  in  1  upstream payload valid.
- in_ready_o  out  1  stage can accept; registered.
- in_data_i  in  DATA_W  upstream payload.
- out_valid_o  out  1  output register holds a valid payload.
- out_ready_i  in  1  downstream can accept.
- out_data_o  out  DATA_W  output register contents.
- stall_i  in  1  hazard-unit stall; holds the output.
- flush_i  in  1  hazard-unit flush; discards contents.

Behaviour:
- Definitions:
  - accept = in_valid_i & in_ready_o.
  - fire = out_valid_o & out_ready_i & ~stall_i.
- Storage:
  - main register (drives out_data_o) and skid register.
  - State enum: EMPTY, ONE, FULL.
  - out_valid_o = (state != EMPTY).
  - in_ready_o = (state != FULL), registered.
- Reset (rst=1 at a clk edge):
  - state=EMPTY, main=FLUSH_VAL, skid=FLUSH_VAL.
  - out_valid_o=0, in_ready_o=1, counters=0.
  - Reset takes priority over all other inputs, including mid-transfer.
- Flush (flush_i=1, rst=0):
  - Next state=EMPTY, main=FLUSH_VAL, skid=FLUSH_VAL.
  - Any accept in the same cycle is dropped.
  - Flush has priority over stall and over accept/fire.
- Transitions when neither rst nor flush is asserted:
  - EMPTY, accept: main<=in_data_i, go to ONE.
  - EMPTY, no accept: hold.
  - ONE, accept & fire: main<=in_data_i, stay in ONE.
  - ONE, accept & ~fire: skid<=in_data_i, go to FULL.
  - ONE, ~accept & fire: main<=FLUSH_VAL, go to EMPTY.
  - ONE, neither: hold.
  - FULL, fire: main<=skid, skid<=FLUSH_VAL, go to ONE.
  - FULL, no fire: hold. No accept is possible in FULL since in_ready_o=0.
- Latency and throughput:
  - Latency is 1 cycle from accept in EMPTY to out_valid_o=1.
  - Sustained throughput is 1 payload per cycle when no stall or backpressure occurs.
- Ordering: strict FIFO. A payload is never duplicated or lost except by flush.
- Stall:
  - stall_i=1 behaves exactly like out_ready_i=0.
  - Contents are held; one further input can still be absorbed into skid.
- in_valid_i may drop without a transfer; no upstream hold rule is enforced.
- out_data_o is stable while out_valid_o=1 and not fire.

Optional Feature:
- Macro: PIPE_STAGE_PERF_EN.
- Defined:
  - Adds outputs stall_cnt_o[CNT_W] (cycles with out_valid_o & ~(out_ready_i & ~stall_i)) and flush_cnt_o[CNT_W] (cycles with flush_i=1).
  - Both counters wrap modulo 2^CNT_W, are cleared by rst, and are not cleared by flush.
- Undefined: these ports and counters do not exist; the rest of the behaviour is identical.

Decomposition:
- Shared package pipe_pkg holds:
  - state enum stage_state_t {EMPTY, ONE, FULL}.
  - localparam NOP_INSTR = 32'h00000013.
  - packed struct fd_payload_t {instr, pc, pcplus4}, each 32 bits.
  - default FLUSH_VAL built from NOP_INSTR.
- Sub-module pipe_perf_cnt: one saturation-free wrapping counter with inc and synchronous clear. It is instantiated twice, only under PIPE_STAGE_PERF_EN.

Test Plan:
- Reset then idle, with rst=1 for 2 cycles -> out_valid_o=0, in_ready_o=1, out_data_o=96'h00000013_00000000_00000000.
- Streaming: in_data_i=A,B,C on consecutive cycles, out_ready_i=1 -> out_data_o=A,B,C on cycles 1,2,3, each with out_valid_o=1, in_ready_o never 0.
- Skid fill: A then B accepted while stall_i=1 -> state FULL, in_ready_o=0, out_data_o=A held. Release stall -> A, then B on the next cycle, in_ready_o=1 one cycle after A fires.
- Flush priority: state FULL, flush_i=1 together with out_ready_i=1 and stall_i=1 -> next cycle out_valid_o=0, out_data_o=FLUSH_VAL, in_ready_o=1. Neither A nor B ever appears.
- Flush versus accept: in_valid_i=1, in_data_i=D, flush_i=1 in the same cycle -> D is dropped and out_valid_o=0 next cycle.
- Drain to bubble and counters: accept A, fire with no new input -> out_valid_o=0, out_data_o=FLUSH_VAL. With PIPE_STAGE_PERF_EN, 3 stalled-valid cycles plus 1 flush cycle -> stall_cnt_o=3, flush_cnt_o=1.
